// File: rtl/ctrl_pkg.sv
// Shared definitions for the Fibonacci/Timer sequencing controller:
// state encoding, one-hot LED patterns and the frequency-code width.
package ctrl_pkg;

  localparam int PROG_W = 3;
  localparam int LED_W  = 6;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FIB    = 3'd1,
    S_STOP_F = 3'd2,
    S_TIM    = 3'd3,
    S_STOP_T = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [LED_W-1:0] LED_INIT   = 6'b000001;
  localparam logic [LED_W-1:0] LED_FIB    = 6'b000010;
  localparam logic [LED_W-1:0] LED_STOP_F = 6'b000100;
  localparam logic [LED_W-1:0] LED_TIM    = 6'b001000;
  localparam logic [LED_W-1:0] LED_STOP_T = 6'b010000;
  localparam logic [LED_W-1:0] LED_DONE   = 6'b100000;

endpackage

// File: rtl/fsm_ctrl.sv
// Sequencing controller: chooses which generator (Fibonacci or Timer) runs,
// pauses or restarts, selects the displayed value, drives the state LEDs and
// latches the slow-clock frequency code for the divider.
module fsm_ctrl
  import ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_f,
  input  logic              start_t,
  input  logic              stop_f_t,
  input  logic              update,
  input  logic [PROG_W-1:0] prog,
  input  logic              f_done,
  input  logic              t_done,
  output logic              en_fib,
  output logic              en_tim,
  output logic              fib_clr,
  output logic              tim_clr,
  output logic              disp_sel,
  output logic [PROG_W-1:0] prog_q,
  output logic              prog_load,
  output logic [LED_W-1:0]  led
);

  state_t state, next_state;
  logic   fib_clr_set, tim_clr_set;
  logic   disp_sel_next;
  logic   f_done_ok, t_done_ok;

  // A done level is ignored while its generator is being cleared, so a stale
  // done from the previous run cannot bounce us straight back into DONE.
  assign f_done_ok = f_done & ~fib_clr;
  assign t_done_ok = t_done & ~tim_clr;

  // State register plus the registered entry flags (clear pulses, display select).
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; reset here is synchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_INIT;
      fib_clr  <= 1'b0;
      tim_clr  <= 1'b0;
      disp_sel <= 1'b0;
    end else begin
      state    <= next_state;
      fib_clr  <= fib_clr_set;
      tim_clr  <= tim_clr_set;
      disp_sel <= disp_sel_next;
    end
  end

  // Next-state logic; priority is stop_f_t > done > start_f > start_t.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    next_state  = state;
    fib_clr_set = 1'b0;
    tim_clr_set = 1'b0;
    unique case (state)
      S_INIT, S_DONE: begin
        // Fresh start: the chosen generator is cleared on entry.
        if (start_f) begin
          next_state  = S_FIB;
          fib_clr_set = 1'b1;
        end else if (start_t) begin
          next_state  = S_TIM;
          tim_clr_set = 1'b1;
        end
      end
      S_FIB: begin
        if (stop_f_t)       next_state = S_STOP_F;
        else if (f_done_ok) next_state = S_DONE;
        else if (start_t)   next_state = S_TIM;   // Timer resumes its value
      end
      S_TIM: begin
        if (stop_f_t)       next_state = S_STOP_T;
        else if (t_done_ok) next_state = S_DONE;
        else if (start_f)   next_state = S_FIB;   // Fibonacci resumes its value
      end
      S_STOP_F, S_STOP_T: begin
        if (start_f)      next_state = S_FIB;
        else if (start_t) next_state = S_TIM;
      end
      default: next_state = S_INIT;
    endcase

    // Display follows the entered state; DONE keeps the finished generator shown.
    unique case (next_state)
      S_TIM, S_STOP_T: disp_sel_next = 1'b1;
      S_DONE:          disp_sel_next = disp_sel;
      default:         disp_sel_next = 1'b0;
    endcase
  end

  // Moore output decode from the state register.
  always_comb begin
    en_fib = (state == S_FIB);
    en_tim = (state == S_TIM);
    unique case (state)
      S_INIT:   led = LED_INIT;
      S_FIB:    led = LED_FIB;
      S_STOP_F: led = LED_STOP_F;
      S_TIM:    led = LED_TIM;
      S_STOP_T: led = LED_STOP_T;
      S_DONE:   led = LED_DONE;
      default:  led = LED_INIT;
    endcase
  end

  // Frequency code capture; the strobe marks the cycle after each capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      prog_q    <= '0;
      prog_load <= 1'b0;
    end else begin
      if (update) prog_q <= prog;
      prog_load <= update;
    end
  end

endmodule

// File: doc/fsm_ctrl.md
# fsm_ctrl

Sequencing controller for the Fibonacci/Timer display system. It sits between the button edge detectors and the two datapath generators, Fibonacci and Timer. It decides which generator runs, pauses or restarts, and selects which value the display shows. It also drives the state LEDs and latches the slow-clock frequency selection for the clock divider.

## Interface
Parameters:
- none; state and LED encodings come from the shared package.

Ports:
- clk  in  1  100 MHz system clock
- rst  in  1  synchronous, active-high reset
- start_f  in  1  one-cycle pulse (already edge-detected): start or continue Fibonacci
- start_t  in  1  one-cycle pulse: start or continue Timer
- stop_f_t  in  1  one-cycle pulse: pause the running generator
- update  in  1  one-cycle pulse: load prog into the divider
- prog  in  3  requested slow-clock frequency code
- f_done  in  1  level from Fibonacci: sequence reached its final value
- t_done  in  1  level from Timer: count reached its maximum
- en_fib  out  1  Fibonacci advance enable (level)
- en_tim  out  1  Timer advance enable (level)
- fib_clr  out  1  one-cycle clear to Fibonacci
- tim_clr  out  1  one-cycle clear to Timer
- disp_sel  out  1  0 = show Fibonacci value, 1 = show Timer value
- prog_q  out  3  latched frequency code for the divider
- prog_load  out  1  one-cycle strobe: prog_q has changed
- led  out  6  one-hot current state

## Operation
States (LED bit in parentheses):
- INIT (0): after reset.
- FIB (1): Fibonacci running.
- STOP_F (2): Fibonacci paused.
- TIM (3): Timer running.
- STOP_T (4): Timer paused.
- DONE (5): a generator finished.

Transitions (priority within one cycle is stop_f_t > done > start_f > start_t):
- INIT: start_f -> FIB with fib_clr; start_t -> TIM with tim_clr.
- FIB: stop_f_t -> STOP_F; f_done -> DONE; start_t -> TIM, no clear (Timer resumes its value); start_f is ignored.
- TIM: stop_f_t -> STOP_T; t_done -> DONE; start_f -> FIB, no clear; start_t is ignored.
- STOP_F: start_f -> FIB (resume); start_t -> TIM (resume); stop_f_t is ignored.
- STOP_T: symmetric to STOP_F.
- DONE: start_f -> FIB with fib_clr; start_t -> TIM with tim_clr; stop_f_t is ignored.

Output decode (Moore, from the state register):
- en_fib = FIB; en_tim = TIM.
- disp_sel = 1 in TIM and STOP_T; 0 in INIT, FIB and STOP_F.
- In DONE, disp_sel holds its previous value, so the finished generator stays on the display.
- Clear pulses come from a registered entry flag set on the qualifying transition.
- While fib_clr (tim_clr) is high, f_done (t_done) is ignored. This prevents a stale done level from bouncing the controller straight back to DONE.

Frequency update:
- update is accepted in every state, with no effect on the state machine.
- prog is captured into prog_q at the sampling edge; prog_load pulses in the cycle after the capture.
- Back-to-back updates each produce their own strobe; the last value wins.

Reset values:
- state INIT, led 6'b000001.
- en_fib, en_tim, fib_clr, tim_clr, prog_load all 0.
- disp_sel 0, prog_q 3'd0.
- Reset mid-operation returns to INIT within one cycle and discards any pending clear or strobe.

## Timing
- A pulse sampled at edge N updates the state at edge N; outputs reflect the new state in cycle N+1 (one-cycle latency).
- fib_clr/tim_clr are high for exactly cycle N+1, coincident with the first enable cycle. The generators must give clear priority over enable.
- Done inputs are sampled synchronously; the effect is seen the cycle after.
- The controller has no knowledge of the slow clock; the enables are levels that the generators qualify with their own tick.

## Structure
- Package ctrl_pkg holds:
  - the state enum (6 values);
  - the LED one-hot constants, one per state;
  - the width constant for prog (3).
- One flat module with no sub-module. Button debouncing and edge detection stay outside this block.

## Test plan
- Reset, idle 10 cycles -> led=000001; all enables, clears and prog_load 0; prog_q=0.
- start_f at cycle 5 -> cycle 6: led=000010, en_fib=1, fib_clr=1; cycle 7: fib_clr=0. Then stop_f_t -> led=000100, en_fib=0. Then start_t -> led=001000, en_tim=1, tim_clr=0, disp_sel=1.
- In FIB, raise f_done -> led=100000, en_fib=0, disp_sel=0. Then start_f with f_done still high -> FIB with fib_clr=1, no return to DONE; drop f_done next cycle -> remains FIB.
- Same cycle in TIM: stop_f_t=1 and t_done=1 -> STOP_T (stop wins). In INIT, start_f=start_t=1 -> FIB.
- update with prog=5 in TIM -> next cycle prog_q=5, prog_load=1 for one cycle, state unchanged. update with prog=2 on the following cycle -> prog_q=2, second strobe.
- rst asserted one cycle while in TIM with tim_clr high -> next cycle INIT, tim_clr=0, prog_q=0.
